clock_div_ctrl: RTL and testbench
=================================

# clock_div_ctrl

Run-time controller for the state-machine clock divider. It owns a single prescaler counter and sequences its start and stop so that `clk_out` never carries a truncated pulse. It accepts new divisor values over a valid/ready handshake and applies each one only at a half-period boundary. It feeds the slow clock (`clk_out`) and a one-cycle enable strobe (`tick`) to the downstream state machines.

## Interface
- `CNT_W`, 32: width of the counter and the divisor.
- `DEFAULT_DIV`, 10: divisor loaded at reset. The half-period is `DEFAULT_DIV+1` cycles.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run request; level-sensitive.
- `cfg_valid` in 1: a new divisor is offered.
- `cfg_div` in `CNT_W`: offered divisor. The half-period is `cfg_div+1` cycles.
- `cfg_ready` out 1: the controller can accept a divisor.
- `clk_out` out 1: divided clock; idles high.
- `tick` out 1: one-cycle pulse coincident with every `clk_out` toggle.
- `active` out 1: high in RUN and STOPPING.
- `div_cur` out `CNT_W`: divisor currently in effect.

## Operation
- **Reset values.** `counter`=0, `clk_out`=1, `tick`=0, `active`=0, `cfg_ready`=1, `div_cur`=`DEFAULT_DIV`, state OFF. The pending register is cleared.
- **State OFF.** The counter is held at 0 and `clk_out` is held at 1.
  - `en`=1 moves the state to RUN.
  - An accepted config (`cfg_valid & cfg_ready`) writes `div_cur` directly at that edge. `cfg_ready` stays 1.
- **State RUN.** The counter increments every cycle.
  - When `counter==div_cur`, the next edge does all of the following: counter←0, `clk_out`←~`clk_out`, `tick`←1 (`tick` is 0 otherwise).
  - If a config is pending, the same edge also does `div_cur`←pending and `cfg_ready`←1.
  - `en`=0 moves the state to STOPPING. The count is not disturbed.
- **State STOPPING.** Counting continues exactly as in RUN.
  - At a toggle that makes `clk_out` 1, the state goes to OFF and the counter is 0.
  - At a toggle that makes `clk_out` 0, the state stays in STOPPING for one more half-period.
  - `en`=1 returns the state to RUN with the count unchanged.
- **Config in RUN or STOPPING.**
  - Handshake: the edge with `cfg_valid & cfg_ready` stores `cfg_div` into the pending register and sets `cfg_ready`←0.
  - The pending value is applied at the next terminal count. The new value governs the half-period that starts after that toggle.
  - `cfg_ready` is 1 again in the cycle after the apply edge.
- **Simultaneous handshake and terminal count.** The value goes to pending and is not applied at this toggle. It is applied at the following terminal count.
- **Pending config at the toggle into OFF.** It is applied at that same edge.
- **`cfg_div`=0 is legal.** The half-period is 1 cycle and `clk_out` toggles every cycle.
- **Width.** Arithmetic is unsigned, `CNT_W` bits. The counter never exceeds `div_cur`, so no wrap-around occurs.
- **Reset mid-operation.** All registers take their reset values immediately, with no drain phase. A pending config is discarded.

## Timing
- E0 is the edge at which `en`=1 is first sampled in OFF.
  - `active`=1 after E0.
  - The first toggle (`clk_out`→0, `tick`=1) happens at edge E0+`div_cur`+1.
  - Subsequent toggles occur every `div_cur`+1 edges. The period is 2·(`div_cur`+1) cycles.
- Stop latency:
  - If `en` falls while `clk_out`=0, OFF is reached at the next toggle.
  - If `en` falls while `clk_out`=1, OFF is reached two toggles later.
  - `active`=0 in the cycle after the edge that enters OFF.
- Config latency: from handshake to apply is at most 2·(`div_cur`+1) cycles. `cfg_ready` is low for that whole interval.
- Outputs are registered; there is no combinational path from the inputs.

## Test plan
- **Reset then run.** Release reset with `en`=1 and defaults → `clk_out` falls at E0+11 and rises at E0+22. `tick` pulses at both edges; period 22 cycles.
- **Config mid-run.** With `div_cur`=10 running, handshake `cfg_div`=3 at counter=4 → `cfg_ready`=0. The current half-period still ends at 11 cycles. After that toggle, half-periods are 4 cycles and `div_cur`=3.
- **Handshake on terminal count.** Handshake `cfg_div`=5 in the cycle `counter==div_cur` → the toggle uses the old divisor. The next half-period also uses the old divisor. A 6-cycle half-period begins after that.
- **Stop while high.** Drop `en` while `clk_out`=1 with `div_cur`=2 → exactly one low phase of 3 cycles, then OFF with `clk_out`=1, `active`=0 and counter 0.
- **Stop and resume.** Drop `en` while `clk_out`=0, then reassert it 1 cycle later → no glitch and no phase reset; toggle spacing stays `div_cur`+1.
- **Asynchronous reset mid-run.** Assert `rst` mid-run with a config pending → immediately `clk_out`=1, `tick`=0, `cfg_ready`=1, `div_cur`=10. The pending value is never applied.

Source files
------------

// File: rtl/clock_div_ctrl_if.sv
// Control/status bundle between the divider controller and its user:
// run request, divisor handshake, and the divided clock outputs.
interface clock_div_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic             active;
    logic [CNT_W-1:0] div_cur;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, clk_out, tick, active, div_cur
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, clk_out, tick, active, div_cur
    );
endinterface

// File: rtl/clock_div_ctrl.sv
// Run-time controller for the clock divider: one prescaler counter, glitch-free
// start/stop sequencing, and divisor updates applied only at half-period boundaries.
module clock_div_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input logic             clk,
    input logic             rst,
    clock_div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    state_t           state_r,     state_s;
    logic [CNT_W-1:0] counter_r,   counter_s;
    logic             clk_out_r,   clk_out_s;
    logic             tick_r,      tick_s;
    logic             active_r,    active_s;
    logic             cfg_ready_r, cfg_ready_s;
    logic [CNT_W-1:0] div_cur_r,   div_cur_s;
    logic [CNT_W-1:0] pend_r,      pend_s;
    logic             hs_s;
    logic             tc_s;

    // Register all controller state; reset drops everything with no drain phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_OFF;
            counter_r   <= '0;
            clk_out_r   <= 1'b1;
            tick_r      <= 1'b0;
            active_r    <= 1'b0;
            cfg_ready_r <= 1'b1;
            div_cur_r   <= DIV_RST;
            pend_r      <= '0;
        end else begin
            state_r     <= state_s;
            counter_r   <= counter_s;
            clk_out_r   <= clk_out_s;
            tick_r      <= tick_s;
            active_r    <= active_s;
            cfg_ready_r <= cfg_ready_s;
            div_cur_r   <= div_cur_s;
            pend_r      <= pend_s;
        end
    end

    // Next-state and next-output logic for the OFF/RUN/STOPPING sequencer.
    always_comb begin
        state_s     = state_r;
        counter_s   = counter_r;
        clk_out_s   = clk_out_r;
        tick_s      = 1'b0;
        cfg_ready_s = cfg_ready_r;
        div_cur_s   = div_cur_r;
        pend_s      = pend_r;
        hs_s        = bus.cfg_valid & cfg_ready_r;
        tc_s        = (counter_r == div_cur_r);

        case (state_r)
            ST_OFF: begin
                counter_s   = '0;
                clk_out_s   = 1'b1;
                cfg_ready_s = 1'b1;
                // While stopped there is no boundary to wait for.
                if (hs_s) begin
                    div_cur_s = bus.cfg_div;
                end else begin
                    div_cur_s = div_cur_r;
                end
                if (bus.en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_OFF;
                end
            end

            ST_RUN, ST_STOPPING: begin
                if (tc_s) begin
                    counter_s = '0;
                    clk_out_s = ~clk_out_r;
                    tick_s    = 1'b1;
                    // A low cfg_ready while running means a divisor is pending.
                    if (!cfg_ready_r) begin
                        div_cur_s   = pend_r;
                        cfg_ready_s = 1'b1;
                    end else begin
                        div_cur_s   = div_cur_r;
                    end
                end else begin
                    counter_s = counter_r + CNT_W'(1);
                end

                // hs_s needs cfg_ready high, so it never collides with an apply.
                if (hs_s) begin
                    pend_s      = bus.cfg_div;
                    cfg_ready_s = 1'b0;
                end else begin
                    pend_s      = pend_r;
                end

                if (bus.en) begin
                    state_s = ST_RUN;
                end else if (state_r == ST_RUN) begin
                    state_s = ST_STOPPING;
                end else if (tc_s && !clk_out_r) begin
                    state_s = ST_OFF;
                end else begin
                    state_s = ST_STOPPING;
                end
            end

            default: begin
                state_s     = ST_OFF;
                counter_s   = '0;
                clk_out_s   = 1'b1;
                cfg_ready_s = 1'b1;
            end
        endcase

        active_s = (state_s != ST_OFF);
    end

    assign bus.cfg_ready = cfg_ready_r;
    assign bus.clk_out   = clk_out_r;
    assign bus.tick      = tick_r;
    assign bus.active    = active_r;
    assign bus.div_cur   = div_cur_r;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Self-checking bench for clock_div_ctrl: a table of input phases with the
// outputs expected after each phase, plus an asynchronous-reset sequence.
module tb_clock_div_ctrl;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_div_ctrl_if #(.CNT_W(CNT_W)) bus ();

    clock_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             do_rst;
        logic             en;
        logic             cv;
        logic [CNT_W-1:0] cd;
        int               n;
        logic             clk_out;
        logic             tick;
        logic             active;
        logic             rdy;
        logic [CNT_W-1:0] div_cur;
        int               nticks;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t v(input logic r, input logic e, input logic c,
                               input logic [CNT_W-1:0] d, input int n,
                               input logic co, input logic t, input logic a,
                               input logic rdy, input logic [CNT_W-1:0] dc,
                               input int nt);
        vec_t x;
        x.do_rst = r;  x.en = e;   x.cv = c;      x.cd = d;       x.n = n;
        x.clk_out = co; x.tick = t; x.active = a; x.rdy = rdy;    x.div_cur = dc;
        x.nticks = nt;
        return x;
    endfunction

    task automatic chk(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".clk_out"},   bus.clk_out,   1);
        chk({tag, ".tick"},      bus.tick,      0);
        chk({tag, ".active"},    bus.active,    0);
        chk({tag, ".cfg_ready"}, bus.cfg_ready, 1);
        chk({tag, ".div_cur"},   bus.div_cur,   10);
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives.
    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   ticks;

        //                 rst  en   cv   cd  n   clk  tick act  rdy  div nt
        // Reset then run with default divisor 10
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b1,1'b0,1'b1,1'b1,10, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0,10, 1'b1,1'b0,1'b1,1'b1,10, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b0,1'b1,1'b1,1'b1,10, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b0,1'b0,1'b1,1'b1,10, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 9, 1'b0,1'b0,1'b1,1'b1,10, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b1,1'b1,1'b1,1'b1,10, 1));
        // Config 3 offered at counter 4; old half-period finishes first
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 4, 1'b1,1'b0,1'b1,1'b1,10, 0));
        vecs.push_back(v(1'b0,1'b1,1'b1, 3, 1, 1'b1,1'b0,1'b1,1'b0,10, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 5, 1'b1,1'b0,1'b1,1'b0,10, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b0,1'b1,1'b1,1'b1, 3, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 3, 1'b0,1'b0,1'b1,1'b1, 3, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b1,1'b1,1'b1,1'b1, 3, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 4, 1'b0,1'b1,1'b1,1'b1, 3, 1));
        // Handshake on the terminal-count edge: one more old half-period
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 3, 1'b0,1'b0,1'b1,1'b1, 3, 0));
        vecs.push_back(v(1'b0,1'b1,1'b1, 5, 1, 1'b1,1'b1,1'b1,1'b0, 3, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 3, 1'b1,1'b0,1'b1,1'b0, 3, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b0,1'b1,1'b1,1'b1, 5, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 5, 1'b0,1'b0,1'b1,1'b1, 5, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b1,1'b1,1'b1,1'b1, 5, 1));
        // Switch to divisor 2, then stop while clk_out is high
        vecs.push_back(v(1'b0,1'b1,1'b1, 2, 1, 1'b1,1'b0,1'b1,1'b0, 5, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 5, 1'b0,1'b1,1'b1,1'b1, 2, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 3, 1'b1,1'b1,1'b1,1'b1, 2, 1));
        vecs.push_back(v(1'b0,1'b0,1'b0, 0, 1, 1'b1,1'b0,1'b1,1'b1, 2, 0));
        vecs.push_back(v(1'b0,1'b0,1'b0, 0, 2, 1'b0,1'b1,1'b1,1'b1, 2, 1));
        vecs.push_back(v(1'b0,1'b0,1'b0, 0, 2, 1'b0,1'b0,1'b1,1'b1, 2, 0));
        vecs.push_back(v(1'b0,1'b0,1'b0, 0, 1, 1'b1,1'b1,1'b0,1'b1, 2, 1));
        vecs.push_back(v(1'b0,1'b0,1'b0, 0, 3, 1'b1,1'b0,1'b0,1'b1, 2, 0));
        // Config while OFF lands immediately; then stop-and-resume while low
        vecs.push_back(v(1'b0,1'b0,1'b1, 3, 1, 1'b1,1'b0,1'b0,1'b1, 3, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b1,1'b0,1'b1,1'b1, 3, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 4, 1'b0,1'b1,1'b1,1'b1, 3, 1));
        vecs.push_back(v(1'b0,1'b0,1'b0, 0, 1, 1'b0,1'b0,1'b1,1'b1, 3, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 2, 1'b0,1'b0,1'b1,1'b1, 3, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b1,1'b1,1'b1,1'b1, 3, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 4, 1'b0,1'b1,1'b1,1'b1, 3, 1));
        // Leave divisor 7 pending, then reset mid-run: it must never apply
        vecs.push_back(v(1'b0,1'b1,1'b1, 7, 1, 1'b0,1'b0,1'b1,1'b0, 3, 0));
        vecs.push_back(v(1'b1,1'b1,1'b0, 0, 1, 1'b1,1'b0,1'b1,1'b1,10, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0,11, 1'b0,1'b1,1'b1,1'b1,10, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0,11, 1'b1,1'b1,1'b1,1'b1,10, 1));
        vecs.push_back(v(1'b0,1'b0,1'b0, 0,22, 1'b1,1'b1,1'b0,1'b1,10, 2));
        // Divisor 0: clk_out toggles every cycle
        vecs.push_back(v(1'b0,1'b0,1'b1, 0, 1, 1'b1,1'b0,1'b0,1'b1, 0, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b1,1'b0,1'b1,1'b1, 0, 0));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b0,1'b1,1'b1,1'b1, 0, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 1, 1'b1,1'b1,1'b1,1'b1, 0, 1));
        vecs.push_back(v(1'b0,1'b1,1'b0, 0, 5, 1'b0,1'b1,1'b1,1'b1, 0, 5));

        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) async_reset_pulse();
            bus.en        = vecs[i].en;
            bus.cfg_valid = vecs[i].cv;
            bus.cfg_div   = vecs[i].cd;
            exp_q.push_back(vecs[i]);
            ticks = 0;
            for (int k = 0; k < vecs[i].n; k++) begin
                @(posedge clk);
                #1;
                if (bus.tick) ticks++;
            end
            e = exp_q.pop_front();
            chk($sformatf("v%0d.clk_out", i),   bus.clk_out,   e.clk_out);
            chk($sformatf("v%0d.tick", i),      bus.tick,      e.tick);
            chk($sformatf("v%0d.active", i),    bus.active,    e.active);
            chk($sformatf("v%0d.cfg_ready", i), bus.cfg_ready, e.rdy);
            chk($sformatf("v%0d.div_cur", i),   bus.div_cur,   e.div_cur);
            chk($sformatf("v%0d.ticks", i),     ticks,         e.nticks);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
